dcache_sa: RTL and testbench

Parametrised set-associative, write-back, write-allocate data cache with multi-word lines, true-LRU replacement, byte strobes and a valid/ready handshake on both CPU and memory sides. It sits between the core load/store unit and the memory bus and supersedes the single-word direct-mapped dcache. A miss runs a burst FSM: optional dirty write-back, then line refill.

---
 rtl/dcache_sa.sv | 237 +++++++++++++++++++++++
 tb/tb_dcache_sa.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_sa.sv
// rtl/dcache_sa.sv - set-associative write-back write-allocate data cache with burst refill
module dcache_sa #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_SETS   = 64,
    parameter int WAYS       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        mem_req,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int OFF  = $clog2(LINE_WORDS * 4);
    localparam int IDXW = $clog2(NUM_SETS);
    localparam int TAGW = 32 - OFF - IDXW;
    localparam int WSW  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int AW   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WBACK, S_REFILL, S_RESP} state_t;

    state_t            r_state;
    logic              r_write;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [TAGW-1:0]   r_tag_q;
    logic [IDXW-1:0]   r_idx;
    logic [WSW-1:0]    r_word;
    logic [AW-1:0]     r_victim;
    logic [WSW-1:0]    r_beat;

    logic [NUM_SETS-1:0] r_valid [WAYS];
    logic [NUM_SETS-1:0] r_dirty [WAYS];
    logic [TAGW-1:0]     r_tags  [WAYS][NUM_SETS];
    logic [AW-1:0]       r_age   [WAYS][NUM_SETS];
    logic [31:0]         r_data  [WAYS][NUM_SETS][LINE_WORDS];

    logic              w_hit;
    logic              w_free;
    logic [AW-1:0]     w_hit_way;
    logic [AW-1:0]     w_victim;
    logic [31:0]       w_hit_word;
    logic [31:0]       w_merged;
    logic [31:0]       w_fill;
    logic [WSW-1:0]    w_beat_nxt;
    logic              w_last;
    logic              w_lru_en;
    logic [AW-1:0]     w_lru_way;
    logic              w_unused;

    // byte-lane merge of store data into an existing word
    function automatic logic [31:0] f_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] strb);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

    // word-aligned address of one beat within a line
    function automatic logic [31:0] f_beat_addr(input logic [TAGW-1:0] tag, input logic [IDXW-1:0] idx,
                                                input logic [WSW-1:0] beat);
        logic [31:0] a;
        a = {tag, idx, {OFF{1'b0}}};
        a = a | (32'(beat) << 2);
        return a;
    endfunction

    assign w_unused   = ^req_addr[1:0];
    assign w_hit_word = r_data[w_hit_way][r_idx][r_word];
    assign w_merged   = f_merge(w_hit_word, r_wdata, r_wstrb);
    assign w_fill     = (r_write && (r_beat == r_word)) ? f_merge(mem_rdata, r_wdata, r_wstrb) : mem_rdata;
    assign w_beat_nxt = r_beat + 1'b1;
    assign w_last     = (r_beat == WSW'(LINE_WORDS - 1));
    assign w_lru_en   = ((r_state == S_LOOKUP) && w_hit) || ((r_state == S_REFILL) && mem_ready && w_last);
    assign w_lru_way  = (r_state == S_LOOKUP) ? w_hit_way : r_victim;

    // tag match across all ways, plus victim choice: lowest invalid way, else the oldest
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_free    = 1'b0;
        w_victim  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w][r_idx] && (r_tags[w][r_idx] == r_tag_q)) begin
                w_hit     = 1'b1;
                w_hit_way = AW'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w][r_idx]) begin
                w_free   = 1'b1;
                w_victim = AW'(w);
            end
        end
        if (!w_free) begin
            for (int w = 0; w < WAYS; w++) begin
                if (r_age[w][r_idx] == AW'(WAYS - 1)) w_victim = AW'(w);
            end
        end
    end

    // control FSM, registered outputs, cache arrays and LRU ages
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            mem_req    <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_tag_q    <= '0;
            r_idx      <= '0;
            r_word     <= '0;
            r_victim   <= '0;
            r_beat     <= '0;
            for (int w = 0; w < WAYS; w++) begin
                r_valid[w] <= '0;
                r_dirty[w] <= '0;
                for (int s = 0; s < NUM_SETS; s++) r_age[w][s] <= AW'(w);
            end
        end else begin
            resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write   <= req_write;
                        r_wdata   <= req_wdata;
                        r_wstrb   <= req_wstrb;
                        r_tag_q   <= req_addr[31 -: TAGW];
                        r_idx     <= req_addr[OFF +: IDXW];
                        r_word    <= (LINE_WORDS > 1) ? req_addr[2 +: WSW] : '0;
                        req_ready <= 1'b0;
                        r_state   <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        if (r_write) begin
                            r_data[w_hit_way][r_idx][r_word] <= w_merged;
                            r_dirty[w_hit_way][r_idx]        <= 1'b1;
                            resp_rdata                       <= w_merged;
                        end else begin
                            resp_rdata <= w_hit_word;
                        end
                        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 1'b1;
                        r_victim <= w_victim;
                        r_beat   <= '0;
                        mem_req  <= 1'b1;
                        if (r_valid[w_victim][r_idx] && r_dirty[w_victim][r_idx]) begin
                            mem_write <= 1'b1;
                            mem_addr  <= f_beat_addr(r_tags[w_victim][r_idx], r_idx, '0);
                            mem_wdata <= r_data[w_victim][r_idx][0];
                            r_state   <= S_WBACK;
                        end else begin
                            mem_write <= 1'b0;
                            mem_addr  <= f_beat_addr(r_tag_q, r_idx, '0);
                            r_state   <= S_REFILL;
                        end
                    end
                end
                S_WBACK: begin
                    if (mem_ready) begin
                        if (w_last) begin
                            r_beat    <= '0;
                            mem_write <= 1'b0;
                            mem_addr  <= f_beat_addr(r_tag_q, r_idx, '0);
                            r_state   <= S_REFILL;
                        end else begin
                            r_beat    <= w_beat_nxt;
                            mem_addr  <= f_beat_addr(r_tags[r_victim][r_idx], r_idx, w_beat_nxt);
                            mem_wdata <= r_data[r_victim][r_idx][w_beat_nxt];
                        end
                    end
                end
                S_REFILL: begin
                    if (mem_ready) begin
                        // a pending store is folded into its word as that word arrives
                        r_data[r_victim][r_idx][r_beat] <= w_fill;
                        if (r_beat == r_word) resp_rdata <= w_fill;
                        if (w_last) begin
                            mem_req                  <= 1'b0;
                            r_tags[r_victim][r_idx]  <= r_tag_q;
                            r_valid[r_victim][r_idx] <= 1'b1;
                            r_dirty[r_victim][r_idx] <= r_write;
                            r_state                  <= S_RESP;
                        end else begin
                            r_beat   <= w_beat_nxt;
                            mem_addr <= f_beat_addr(r_tag_q, r_idx, w_beat_nxt);
                        end
                    end
                end
                S_RESP: begin
                    resp_valid <= 1'b1;
                    req_ready  <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
            if (w_lru_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (r_age[w][r_idx] < r_age[w_lru_way][r_idx]) r_age[w][r_idx] <= r_age[w][r_idx] + 1'b1;
                end
                r_age[w_lru_way][r_idx] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dcache_sa.sv
// tb/tb_dcache_sa.sv - scoreboard bench for dcache_sa
module tb_dcache_sa;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_req;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    always #5 clk = ~clk;

    dcache_sa #(.LINE_WORDS(4), .NUM_SETS(64), .WAYS(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } beat_t;

    beat_t       obs_q[$];
    beat_t       exp_bq[$];
    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    int          stall_left = 0;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a >= 32'h1000 && a < 32'h1010) return 32'hA0 + ((a - 32'h1000) >> 2);
        return a ^ 32'hC0DE_0000;
    endfunction

    // memory responder: decides mem_ready / mem_rdata for the coming edge and logs completing beats
    always @(negedge clk) begin
        if (mem_req && mem_addr == stall_addr && stall_left > 0) begin
            mem_ready = 1'b0;
            stall_left--;
        end else begin
            mem_ready = 1'b1;
        end
        mem_rdata = mem_model(mem_addr);
        if (mem_req && mem_ready)
            obs_q.push_back('{w: mem_write, a: mem_addr, d: (mem_write ? mem_wdata : mem_rdata)});
    end

    task automatic exp_reads(input logic [31:0] base);
        for (int b = 0; b < 4; b++)
            exp_bq.push_back('{w: 1'b0, a: base + 32'(4 * b), d: mem_model(base + 32'(4 * b))});
    endtask

    task automatic drive_req(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        @(negedge clk);
        for (int i = 0; i < 40 && !req_ready; i++) @(negedge clk);
        req_write = w;
        req_addr  = a;
        req_wdata = wd;
        req_wstrb = ws;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input logic [31:0] exp, output logic [31:0] rd, output int lat);
        exp_q.push_back(exp);
        drive_req(w, a, wd, ws);
        lat = -1;
        rd  = '0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = k;
                rd  = resp_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({req_ready, resp_valid, mem_req, mem_write} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_ctrl got %b exp 1000", {req_ready, resp_valid, mem_req, mem_write});
        end
        n_cmp++;
        if ({resp_rdata, mem_addr, mem_wdata, hit_cnt, miss_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_data got rd=%h ma=%h wd=%h h=%0d m=%0d exp all 0",
                     resp_rdata, mem_addr, mem_wdata, hit_cnt, miss_cnt);
        end
        obs_q.delete();
    endtask

    task automatic test_cold_load;
        logic [31:0] rd, e;
        int lat;
        exp_reads(32'h1000);
        do_req(1'b0, 32'h1000, '0, '0, 32'hA0, rd, lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (lat < 0 || rd !== e) begin n_bad++; $display("FAIL cold_rdata got %h (lat %0d) exp %h", rd, lat, e); end
        n_cmp++;
        if (obs_q.size() != exp_bq.size()) begin
            n_bad++; $display("FAIL cold_beat_count got %0d exp %0d", obs_q.size(), exp_bq.size());
        end else begin
            for (int i = 0; i < exp_bq.size(); i++) begin
                n_cmp++;
                if (obs_q[i] !== exp_bq[i]) begin n_bad++; $display("FAIL cold_beat%0d got %h exp %h", i, obs_q[i], exp_bq[i]); end
            end
        end
        obs_q.delete(); exp_bq.delete();
        n_cmp++;
        if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin
            n_bad++; $display("FAIL cold_counters got h=%0d m=%0d exp h=0 m=1", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_hit;
        logic [31:0] rd, e;
        int lat;
        do_req(1'b0, 32'h1004, '0, '0, 32'hA1, rd, lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (lat < 0 || rd !== e) begin n_bad++; $display("FAIL hit_rdata got %h exp %h", rd, e); end
        n_cmp++;
        if (lat != 3) begin n_bad++; $display("FAIL hit_latency got %0d exp 3", lat); end
        n_cmp++;
        if (obs_q.size() != 0) begin n_bad++; $display("FAIL hit_no_mem got %0d beats exp 0", obs_q.size()); end
        obs_q.delete();
        n_cmp++;
        if (hit_cnt !== 32'd1) begin n_bad++; $display("FAIL hit_count got %0d exp 1", hit_cnt); end
    endtask

    task automatic test_strobes;
        logic [31:0] ad [3] = '{32'h1008, 32'h1008, 32'h1008};
        logic        wr [3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] wd [3] = '{32'hDEAD_BEEF, 32'h0000_1234, 32'h0};
        logic [3:0]  ws [3] = '{4'hF, 4'h3, 4'h0};
        logic [31:0] ex [3] = '{32'hDEAD_BEEF, 32'hDEAD_1234, 32'hDEAD_1234};
        logic [31:0] rd, e;
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_req(wr[i], ad[i], wd[i], ws[i], ex[i], rd, lat);
            e = exp_q.pop_front();
            n_cmp++;
            if (lat != 3 || rd !== e) begin n_bad++; $display("FAIL strobe_req%0d got %h lat %0d exp %h lat 3", i, rd, lat, e); end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin n_bad++; $display("FAIL strobe_no_mem got %0d beats exp 0", obs_q.size()); end
        obs_q.delete();
        n_cmp++;
        if (hit_cnt !== 32'd4 || miss_cnt !== 32'd1) begin
            n_bad++; $display("FAIL strobe_counters got h=%0d m=%0d exp h=4 m=1", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_eviction;
        logic [31:0] ad [4] = '{32'h2000, 32'h1000, 32'h3000, 32'h4000};
        logic [31:0] ex [4] = '{32'hC0DE_2000, 32'hA0, 32'hC0DE_3000, 32'hC0DE_4000};
        logic [31:0] wbd [4] = '{32'hA0, 32'hA1, 32'hDEAD_1234, 32'hA3};
        logic [31:0] rd, e;
        int lat;
        for (int i = 0; i < 4; i++) begin
            if (i == 3)
                for (int b = 0; b < 4; b++) exp_bq.push_back('{w: 1'b1, a: 32'h1000 + 32'(4 * b), d: wbd[b]});
            if (i != 1) exp_reads(ad[i]);
            do_req(1'b0, ad[i], '0, '0, ex[i], rd, lat);
            e = exp_q.pop_front();
            n_cmp++;
            if (lat < 0 || rd !== e) begin n_bad++; $display("FAIL evict_req%0d rdata got %h exp %h", i, rd, e); end
            n_cmp++;
            if (obs_q.size() != exp_bq.size()) begin
                n_bad++; $display("FAIL evict_req%0d beat_count got %0d exp %0d", i, obs_q.size(), exp_bq.size());
            end else begin
                for (int j = 0; j < exp_bq.size(); j++) begin
                    n_cmp++;
                    if (obs_q[j] !== exp_bq[j]) begin
                        n_bad++; $display("FAIL evict_req%0d beat%0d got %h exp %h", i, j, obs_q[j], exp_bq[j]);
                    end
                end
            end
            obs_q.delete(); exp_bq.delete();
        end
        n_cmp++;
        if (hit_cnt !== 32'd5 || miss_cnt !== 32'd4) begin
            n_bad++; $display("FAIL evict_counters got h=%0d m=%0d exp h=5 m=4", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_stall;
        logic [31:0] e;
        int seen = 0;
        int bad_hold = 0;
        logic got = 1'b0;
        exp_reads(32'h5000);
        exp_q.push_back(32'hC0DE_5000);
        stall_addr = 32'h5004;
        stall_left = 5;
        drive_req(1'b0, 32'h5000, '0, '0);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (resp_valid) begin got = 1'b1; break; end
            if (mem_req && mem_addr == 32'h5004) begin
                seen++;
                if (req_ready !== 1'b0 || mem_write !== 1'b0) bad_hold++;
            end
        end
        stall_addr = 32'hFFFF_FFFF;
        e = exp_q.pop_front();
        n_cmp++;
        if (!got || resp_rdata !== e) begin n_bad++; $display("FAIL stall_rdata got %h exp %h", resp_rdata, e); end
        n_cmp++;
        if (seen != 6) begin n_bad++; $display("FAIL stall_hold_cycles got %0d exp 6", seen); end
        n_cmp++;
        if (bad_hold != 0) begin n_bad++; $display("FAIL stall_ctrl got %0d bad cycles exp 0", bad_hold); end
        n_cmp++;
        if (obs_q.size() != exp_bq.size()) begin
            n_bad++; $display("FAIL stall_beat_count got %0d exp %0d", obs_q.size(), exp_bq.size());
        end else begin
            for (int j = 0; j < exp_bq.size(); j++) begin
                n_cmp++;
                if (obs_q[j] !== exp_bq[j]) begin n_bad++; $display("FAIL stall_beat%0d got %h exp %h", j, obs_q[j], exp_bq[j]); end
            end
        end
        obs_q.delete(); exp_bq.delete();
    endtask

    task automatic test_reset_mid_refill;
        logic [31:0] rd, e;
        int lat;
        logic found = 1'b0;
        drive_req(1'b0, 32'h6000, '0, '0);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #1;
            if (mem_req && mem_addr == 32'h6008) begin found = 1'b1; break; end
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL rst_reach_beat2 got 0 exp 1"); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if ({mem_req, req_ready, resp_valid} !== 3'b010) begin
            n_bad++; $display("FAIL rst_ctrl got %b exp 010", {mem_req, req_ready, resp_valid});
        end
        n_cmp++;
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            n_bad++; $display("FAIL rst_counters got h=%0d m=%0d exp 0 0", hit_cnt, miss_cnt);
        end
        reset = 1'b0;
        obs_q.delete();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 0) begin n_bad++; $display("FAIL rst_no_beats got %0d exp 0", obs_q.size()); end
        obs_q.delete();
        exp_reads(32'h6000);
        do_req(1'b0, 32'h6000, '0, '0, 32'hC0DE_6000, rd, lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (lat < 0 || rd !== e) begin n_bad++; $display("FAIL rst_reload_rdata got %h exp %h", rd, e); end
        n_cmp++;
        if (obs_q.size() != exp_bq.size()) begin
            n_bad++; $display("FAIL rst_beat_count got %0d exp %0d", obs_q.size(), exp_bq.size());
        end else begin
            for (int j = 0; j < exp_bq.size(); j++) begin
                n_cmp++;
                if (obs_q[j] !== exp_bq[j]) begin n_bad++; $display("FAIL rst_beat%0d got %h exp %h", j, obs_q[j], exp_bq[j]); end
            end
        end
        obs_q.delete(); exp_bq.delete();
        n_cmp++;
        if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin
            n_bad++; $display("FAIL rst_reload_counters got h=%0d m=%0d exp h=0 m=1", hit_cnt, miss_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_cold_load;
        test_hit;
        test_strobes;
        test_eviction;
        test_stall;
        test_reset_mid_refill;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
